// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter sharing one 32:1 bit-select mux among NREQ requesters
module mux_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [5*NREQ-1:0] addr_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              rsp_valid_o,
    output logic [2:0]        rsp_id_o,
    output logic              rsp_data_o,
    output logic              busy_o,
    output logic [4:0]        mux_a_o,
    input  logic              mux_dout_i
);

    typedef enum logic {
        IDLE   = 1'b0,
        SAMPLE = 1'b1
    } state_t;

    state_t            state_q;
    logic [2:0]        ptr_q;
    logic [2:0]        cur_id_q;
    logic [4:0]        mux_a_q;
    logic [NREQ-1:0]   gnt_q;
    logic              rsp_valid_q;
    logic [2:0]        rsp_id_q;
    logic              rsp_data_q;

    logic [NREQ-1:0]   cand;
    logic              grant_ok_d;
    logic [2:0]        grant_id_d;
    logic [NREQ-1:0]   grant_vec_d;
    logic [4:0]        grant_addr_d;
    logic [2:0]        ptr_d;
    int                dist_v;
    int                best_v;

    // Pick the candidate closest to ptr going upward; the requester being
    // sampled this cycle is removed so a hog cannot win back-to-back.
    always_comb begin
        cand       = '0;
        grant_ok_d = 1'b0;
        grant_id_d = '0;
        best_v     = NREQ;
        dist_v     = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand[i] = req_i[i] && !((state_q == SAMPLE) && (int'(cur_id_q) == i));
            dist_v  = i - int'(ptr_q);
            if (dist_v < 0) begin
                dist_v = dist_v + NREQ;
            end
            if (cand[i] && (dist_v < best_v)) begin
                best_v     = dist_v;
                grant_id_d = 3'(i);
                grant_ok_d = 1'b1;
            end
        end
    end

    // Decode the winner into its grant vector, its select address and the
    // pointer value that puts it at lowest priority for the next search.
    always_comb begin
        grant_vec_d  = '0;
        grant_addr_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(grant_id_d) == i) begin
                grant_vec_d[i] = grant_ok_d;
                grant_addr_d   = addr_i[5*i +: 5];
            end
        end
        ptr_d = (int'(grant_id_d) == NREQ - 1) ? 3'd0 : grant_id_d + 3'd1;
    end

    // Sequencer: grant in IDLE, sample the mux and optionally re-grant in SAMPLE.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cur_id_q    <= '0;
            mux_a_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (grant_ok_d) begin
                        cur_id_q <= grant_id_d;
                        mux_a_q  <= grant_addr_d;
                        gnt_q    <= grant_vec_d;
                        ptr_q    <= ptr_d;
                        state_q  <= SAMPLE;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                SAMPLE: begin
                    // mux_a_q has been stable for a full cycle, so mux_dout is settled.
                    rsp_data_q  <= mux_dout_i;
                    rsp_id_q    <= cur_id_q;
                    rsp_valid_q <= 1'b1;
                    if (grant_ok_d) begin
                        cur_id_q <= grant_id_d;
                        mux_a_q  <= grant_addr_d;
                        gnt_q    <= grant_vec_d;
                        ptr_q    <= ptr_d;
                    end else begin
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign mux_a_o     = mux_a_q;
    assign busy_o      = (state_q == SAMPLE);

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer that shares one 32:1 bit-select mux among several requesters. Each requester presents a 5-bit select address. The arbiter grants one requester per cycle, drives the shared mux select, and returns the sampled bit tagged with the requester ID. It sits between the requesting units (control/debug bit probes) and the single shared mux instance, whose `A` input it drives and whose `DOUT` output it samples.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `clk`  input  1: clock; all state updates on rising edge.
- `clr`  input  1: asynchronous, active-high reset.
- `req`  input  NREQ: request lines; bit i belongs to requester i.
- `addr`  input  5*NREQ: select address; requester i uses bits [5i+4:5i].
- `gnt`  output  NREQ: registered one-hot grant pulse, one cycle wide.
- `rsp_valid`  output  1: one-cycle pulse; `rsp_id`/`rsp_data` are valid.
- `rsp_id`  output  3: ID of the requester whose bit is returned; upper bits are 0 when NREQ<8.
- `rsp_data`  output  1: sampled mux bit.
- `busy`  output  1: high while a grant is outstanding (state SAMPLE).
- `mux_a`  output  5: registered select, wired to the shared mux `A`.
- `mux_dout`  input  1: shared mux output; combinational function of `mux_a`.

## Operation
- **States:**
  - IDLE: no grant outstanding.
  - SAMPLE: `mux_a` holds the granted address and `gnt` is high for the granted requester.
- **Arbitration:**
  - Candidate set is `req`, excluding `cur_id` when the state is SAMPLE.
  - The search starts at `ptr` and goes upward, wrapping NREQ-1→0. The first set bit wins.
  - `ptr` resets to 0.
  - On every grant, `ptr` ← (winner+1) mod NREQ, so the most recent winner has lowest priority next time.
- **IDLE, rising edge:**
  - If the candidate set is non-empty:
    - `cur_id` ← winner.
    - `mux_a` ← addr of the winner.
    - `gnt` ← one-hot(winner).
    - Go to SAMPLE.
  - Otherwise: `gnt` ← 0 and stay in IDLE.
- **SAMPLE, rising edge:**
  - Always:
    - `rsp_data` ← `mux_dout`.
    - `rsp_id` ← `cur_id`.
    - `rsp_valid` ← 1.
  - If the candidate set (excluding `cur_id`) is non-empty, on the same edge:
    - Latch the new winner into `cur_id`, `mux_a` and `gnt`.
    - `ptr` ← (winner+1) mod NREQ.
    - Stay in SAMPLE.
  - Otherwise: `gnt` ← 0 and go to IDLE.
- **Requester handshake:**
  - A requester holds `req[i]` and its `addr` stable until it sees `gnt[i]`=1.
  - It deasserts `req[i]` at the end of the `gnt` cycle, or keeps it high to issue a new request.
  - `addr` is sampled only on the granting edge. Changes at other times are ignored.
- **Output defaults:**
  - `rsp_valid` is 0 in every cycle not following a SAMPLE cycle.
  - `rsp_data` and `rsp_id` hold their last values when `rsp_valid`=0.
  - `mux_a` holds its last value in IDLE.
- `busy` = (state==SAMPLE).
- **Reset values:** `gnt`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `mux_a`=0, `busy`=0, `ptr`=0, `cur_id`=0, state IDLE.
- **Reset mid-operation:** an outstanding grant is discarded. No `rsp_valid` is produced for it, and arbitration restarts with `ptr`=0.

## Timing
- Request high before edge t (IDLE) → `gnt[i]` and `mux_a` updated after edge t → `rsp_valid` with data after edge t+1. Latency is 2 edges from request to response.
- Sustained throughput is one grant and one response per cycle while at least one other requester is pending.
- A single requester holding `req` continuously is granted every other cycle.
- `mux_dout` is sampled at the end of the cycle in which `mux_a` is stable. The combinational path is `mux_a` → mux → `rsp_data` register.
- `gnt` is at most one-hot in every cycle and is never asserted in IDLE.

## Test plan
- **Reset:** assert `clr` asynchronously mid-cycle → all outputs 0 immediately. After release, all outputs stay 0 with `req`=0.
- **Single request:**
  - Stimulus: NREQ=4; mux D=32'hA5A5_0F0F; req=4'b0100, addr2=5'd8; drop `req` after `gnt`.
  - Response: `gnt`=4'b0100 one cycle after the request; `mux_a`=8. Next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_data`=1. Then idle.
- **Simultaneous requests:**
  - Stimulus: req=4'b1111 from reset, addrs 0,1,2,3; each requester drops `req` on its grant.
  - Response: grants in order 0,1,2,3 on consecutive cycles. Responses with IDs 0,1,2,3 follow one cycle behind, data = D[0..3]. `busy` is high for 4 cycles.
- **Fairness:**
  - Stimulus: req0 and req1 held permanently.
  - Response: grants alternate 0,1,0,1…, never two consecutive grants to the same ID.
- **Hog exclusion:**
  - Stimulus: only req3 held permanently.
  - Response: `gnt[3]` is high every other cycle; `rsp_valid` pulses every other cycle.
- **Reset mid-operation:**
  - Stimulus: assert `clr` in the SAMPLE cycle of a grant to ID 1.
  - Response: no `rsp_valid` for ID 1. After release with req=4'b0011, ID 0 is granted first (`ptr`=0).
